pc_fetch_unit: RTL and testbench

- Parametrised program-counter and fetch-request generator for the pipelined RISC-V core; successor to the plain PC register.
- Holds the PC, drives a req/ack instruction-memory handshake and sequential PC increment.
- Accepts branch and trap redirects at any time, including while a fetch is outstanding, and kills wrong-path fetches.
- Hands a registered {pc, instr, valid} bundle to the IF/ID stage with stall hold.

---
 rtl/pc_fetch_pkg.sv | 17 +
 rtl/pc_fetch_if.sv | 26 ++
 rtl/pc_redirect_sel.sv | 39 +++
 rtl/pc_fetch_unit.sv | 103 ++++++++++
 tb/tb_pc_fetch_unit.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / fetch-request unit.
// Holds the fetch FSM state type, default step/alignment values and standard vectors.
package pc_fetch_pkg;

   typedef enum logic [1:0] {
      StBoot,
      StIdle,
      StReq
   } fetch_state_e;

   localparam int unsigned INC_DEFAULT        = 4;
   localparam int unsigned ALIGN_BITS_DEFAULT = 2;

   localparam logic [31:0] RV_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] RV_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/acknowledge handshake between fetch unit and memory.
// The fetch unit is the master; the memory is the slave.
interface pc_fetch_if #(
   parameter int unsigned XLEN = 32
);

   logic            req;
   logic [XLEN-1:0] addr;
   logic            ack;
   logic [XLEN-1:0] rdata;

   modport master (
      output req,
      output addr,
      input  ack,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output ack,
      output rdata
   );

endinterface

// File: rtl/pc_redirect_sel.sv
// Redirect arbitration: trap > branch > pending redirect, with target alignment.
// misalign_o only reflects current-cycle redirects; the pending target is stored pre-aligned.
module pc_redirect_sel
   import pc_fetch_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned ALIGN_BITS = ALIGN_BITS_DEFAULT
) (
   input  logic            trap_valid_i,
   input  logic [XLEN-1:0] trap_target_i,
   input  logic            br_valid_i,
   input  logic [XLEN-1:0] br_target_i,
   input  logic            pend_valid_i,
   input  logic [XLEN-1:0] pend_target_i,
   output logic            cur_valid_o,
   output logic            redir_valid_o,
   output logic [XLEN-1:0] target_o,
   output logic            misalign_o
);

   localparam logic [XLEN-1:0] AlignMask = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

   logic [XLEN-1:0] raw_target;

   always_comb begin
      raw_target = pend_target_i;
      if (trap_valid_i) begin
         raw_target = trap_target_i;
      end else if (br_valid_i) begin
         raw_target = br_target_i;
      end
   end

   assign cur_valid_o   = trap_valid_i | br_valid_i;
   assign redir_valid_o = cur_valid_o | pend_valid_i;
   assign target_o      = raw_target & AlignMask;
   assign misalign_o    = cur_valid_o & (|(raw_target & ~AlignMask));

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch-request generator with redirect kill and stall-held bundle.
// Redirects arriving while a request is outstanding are parked until the ack retires it.
module pc_fetch_unit
   import pc_fetch_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RV_RESET_VECTOR),
   parameter int unsigned     INC          = INC_DEFAULT,
   parameter int unsigned     ALIGN_BITS   = ALIGN_BITS_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_i,
   input  logic              br_valid_i,
   input  logic [XLEN-1:0]   br_target_i,
   input  logic              trap_valid_i,
   input  logic [XLEN-1:0]   trap_target_i,
   pc_fetch_if.master        imem,
   output logic              fetch_valid_o,
   output logic [XLEN-1:0]   fetch_pc_o,
   output logic [XLEN-1:0]   fetch_instr_o,
   output logic              misalign_o
);

   fetch_state_e    state_q;
   logic [XLEN-1:0] pc_q;
   logic            pend_valid_q;
   logic [XLEN-1:0] pend_target_q;

   logic            cur_valid;
   logic            redir_valid;
   logic [XLEN-1:0] sel_target;
   logic            sel_misalign;

   pc_redirect_sel #(
      .XLEN       (XLEN),
      .ALIGN_BITS (ALIGN_BITS)
   ) u_redirect_sel (
      .trap_valid_i  (trap_valid_i),
      .trap_target_i (trap_target_i),
      .br_valid_i    (br_valid_i),
      .br_target_i   (br_target_i),
      .pend_valid_i  (pend_valid_q),
      .pend_target_i (pend_target_q),
      .cur_valid_o   (cur_valid),
      .redir_valid_o (redir_valid),
      .target_o      (sel_target),
      .misalign_o    (sel_misalign)
   );

   assign imem.req  = (state_q == StReq);
   assign imem.addr = pc_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StBoot;
         pc_q          <= RESET_VECTOR;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
         fetch_valid_o <= 1'b0;
         fetch_pc_o    <= '0;
         fetch_instr_o <= '0;
         misalign_o    <= 1'b0;
      end else begin
         misalign_o <= sel_misalign;
         unique case (state_q)
            StBoot, StIdle: begin
               if (cur_valid) begin
                  pc_q          <= sel_target;
                  fetch_valid_o <= 1'b0;
               end else if (!stall_i) begin
                  fetch_valid_o <= 1'b0;
               end
               state_q <= stall_i ? StIdle : StReq;
            end
            StReq: begin
               if (imem.ack) begin
                  if (redir_valid) begin
                     // Wrong-path instruction: drop it and restart at the target.
                     pc_q          <= sel_target;
                     pend_valid_q  <= 1'b0;
                     fetch_valid_o <= 1'b0;
                  end else begin
                     fetch_valid_o <= 1'b1;
                     fetch_pc_o    <= pc_q;
                     fetch_instr_o <= imem.rdata;
                     pc_q          <= pc_q + XLEN'(INC);
                  end
                  state_q <= stall_i ? StIdle : StReq;
               end else if (cur_valid) begin
                  pend_valid_q  <= 1'b1;
                  pend_target_q <= sel_target;
                  fetch_valid_o <= 1'b0;
               end else if (!stall_i) begin
                  fetch_valid_o <= 1'b0;
               end
            end
            default: state_q <= StBoot;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, delayed ack with redirect,
// trap priority, stall hold, misaligned target, mid-wait reset and PC wrap.
module tb_pc_fetch_unit;

   logic        clk;
   logic        reset;
   logic        stall_i;
   logic        br_valid_i;
   logic [31:0] br_target_i;
   logic        trap_valid_i;
   logic [31:0] trap_target_i;
   logic        fetch_valid_o;
   logic [31:0] fetch_pc_o;
   logic [31:0] fetch_instr_o;
   logic        misalign_o;

   int n_checks = 0;
   int n_errors = 0;

   pc_fetch_if #(.XLEN(32)) imem ();

   pc_fetch_unit #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0000_0000),
      .INC          (4),
      .ALIGN_BITS   (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall_i       (stall_i),
      .br_valid_i    (br_valid_i),
      .br_target_i   (br_target_i),
      .trap_valid_i  (trap_valid_i),
      .trap_target_i (trap_target_i),
      .imem          (imem),
      .fetch_valid_o (fetch_valid_o),
      .fetch_pc_o    (fetch_pc_o),
      .fetch_instr_o (fetch_instr_o),
      .misalign_o    (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One cycle: apply inputs just after the edge, then sample at the falling edge.
   task automatic drive(input logic rst, input logic stall, input logic ack,
                        input logic [31:0] rdata, input logic bv, input logic [31:0] bt,
                        input logic tv, input logic [31:0] tt);
      @(posedge clk);
      #1;
      reset         = rst;
      stall_i       = stall;
      imem.ack      = ack;
      imem.rdata    = rdata;
      br_valid_i    = bv;
      br_target_i   = bt;
      trap_valid_i  = tv;
      trap_target_i = tt;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; stall_i = 1'b0; imem.ack = 1'b0; imem.rdata = '0;
      br_valid_i = 1'b0; br_target_i = '0; trap_valid_i = 1'b0; trap_target_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req",   {31'd0, imem.req},      32'd0);
      chk("rst_addr",  imem.addr,              32'h0);
      chk("rst_valid", {31'd0, fetch_valid_o}, 32'd0);
      chk("rst_pc",    fetch_pc_o,             32'h0);
      chk("rst_instr", fetch_instr_o,          32'h0);
      chk("rst_mis",   {31'd0, misalign_o},    32'd0);

      // Boot cycle, then zero-wait fetches.
      drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      chk("boot_req", {31'd0, imem.req}, 32'd0);
      drive(0, 0, 1, 32'h0000_0013, 0, 32'h0, 0, 32'h0);
      chk("c1_req",  {31'd0, imem.req}, 32'd1);
      chk("c1_addr", imem.addr, 32'h0);
      drive(0, 0, 1, 32'h0010_0093, 0, 32'h0, 0, 32'h0);
      chk("c2_addr",  imem.addr, 32'h4);
      chk("c2_valid", {31'd0, fetch_valid_o}, 32'd1);
      chk("c2_pc",    fetch_pc_o, 32'h0);
      chk("c2_instr", fetch_instr_o, 32'h0000_0013);

      // Ack delayed at 0x8, branch to 0x40 in the first wait cycle.
      drive(0, 0, 0, 32'h0, 1, 32'h40, 0, 32'h0);
      chk("c3_addr",  imem.addr, 32'h8);
      chk("c3_pc",    fetch_pc_o, 32'h4);
      chk("c3_instr", fetch_instr_o, 32'h0010_0093);
      drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      chk("c4_addr",  imem.addr, 32'h8);
      chk("c4_valid", {31'd0, fetch_valid_o}, 32'd0);
      drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      chk("c5_addr", imem.addr, 32'h8);
      drive(0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0, 0, 32'h0);
      chk("c6_addr", imem.addr, 32'h8);
      chk("c6_req",  {31'd0, imem.req}, 32'd1);

      // Trap and branch together: trap wins.
      drive(0, 0, 1, 32'h0, 1, 32'h80, 1, 32'h100);
      chk("c7_addr",  imem.addr, 32'h40);
      chk("c7_valid", {31'd0, fetch_valid_o}, 32'd0);
      drive(0, 0, 1, 32'h0, 1, 32'h10, 0, 32'h0);
      chk("c8_addr",  imem.addr, 32'h100);
      chk("c8_valid", {31'd0, fetch_valid_o}, 32'd0);

      // Fetch 0x10 and stall for four cycles; the ack in IDLE must be ignored.
      drive(0, 1, 1, 32'h1111_1111, 0, 32'h0, 0, 32'h0);
      chk("c9_addr", imem.addr, 32'h10);
      drive(0, 1, 1, 32'h0000_0099, 0, 32'h0, 0, 32'h0);
      chk("stall0_req",   {31'd0, imem.req}, 32'd0);
      chk("stall0_valid", {31'd0, fetch_valid_o}, 32'd1);
      chk("stall0_pc",    fetch_pc_o, 32'h10);
      chk("stall0_instr", fetch_instr_o, 32'h1111_1111);
      chk("stall0_addr",  imem.addr, 32'h14);
      for (int i = 1; i < 3; i++) begin
         drive(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
         chk("stall_req", {31'd0, imem.req}, 32'd0);
         chk("stall_pc",  fetch_pc_o, 32'h10);
         chk("stall_instr", fetch_instr_o, 32'h1111_1111);
      end
      drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      chk("c13_req",   {31'd0, imem.req}, 32'd0);
      chk("c13_valid", {31'd0, fetch_valid_o}, 32'd1);
      drive(0, 0, 1, 32'h2222_2222, 0, 32'h0, 0, 32'h0);
      chk("c14_req",   {31'd0, imem.req}, 32'd1);
      chk("c14_addr",  imem.addr, 32'h14);
      chk("c14_valid", {31'd0, fetch_valid_o}, 32'd0);

      // Misaligned branch target 0x46 -> 0x44, one-cycle misalign pulse.
      drive(0, 0, 0, 32'h0, 1, 32'h46, 0, 32'h0);
      chk("c15_pc",    fetch_pc_o, 32'h14);
      chk("c15_instr", fetch_instr_o, 32'h2222_2222);
      chk("c15_mis",   {31'd0, misalign_o}, 32'd0);
      drive(0, 0, 1, 32'h0000_0055, 0, 32'h0, 0, 32'h0);
      chk("c16_mis",   {31'd0, misalign_o}, 32'd1);
      chk("c16_valid", {31'd0, fetch_valid_o}, 32'd0);
      chk("c16_addr",  imem.addr, 32'h18);
      drive(0, 0, 1, 32'h0, 1, 32'h20, 0, 32'h0);
      chk("c17_mis",  {31'd0, misalign_o}, 32'd0);
      chk("c17_addr", imem.addr, 32'h44);

      // Reset while waiting on 0x20.
      drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      chk("c18_addr", imem.addr, 32'h20);
      drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      chk("c19_req", {31'd0, imem.req}, 32'd1);
      drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      chk("mrst_req",   {31'd0, imem.req}, 32'd0);
      chk("mrst_valid", {31'd0, fetch_valid_o}, 32'd0);
      chk("mrst_addr",  imem.addr, 32'h0);
      chk("mrst_pc",    fetch_pc_o, 32'h0);

      // Fetch at 0xFFFF_FFFC wraps the PC to zero.
      drive(0, 0, 1, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0);
      chk("c21_addr", imem.addr, 32'h0);
      drive(0, 0, 1, 32'h4444_4444, 0, 32'h0, 0, 32'h0);
      chk("c22_addr",  imem.addr, 32'hFFFF_FFFC);
      chk("c22_valid", {31'd0, fetch_valid_o}, 32'd0);
      drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      chk("wrap_addr",  imem.addr, 32'h0);
      chk("wrap_valid", {31'd0, fetch_valid_o}, 32'd1);
      chk("wrap_pc",    fetch_pc_o, 32'hFFFF_FFFC);
      chk("wrap_instr", fetch_instr_o, 32'h4444_4444);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
